// File: rtl/pipe_stage_skid.sv
// Elastic two-entry pipeline register placed between adjacent CPU stages.
// Main entry drives the output, skid entry absorbs one payload when downstream
// stalls. Also provides branch flush, a bubble value, a sticky HLT latch and a
// saturating stall counter.
module pipe_stage_skid #(
    parameter int unsigned         WIDTH   = 16,
    parameter logic [WIDTH-1:0]    NOP_VAL = '0,
    parameter int unsigned         HLT_BIT = 0,
    parameter int unsigned         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic             hlt_seen,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             main_valid, main_valid_n;
    logic [WIDTH-1:0] main_data,  main_data_n;
    logic             skid_valid, skid_valid_n;
    logic [WIDTH-1:0] skid_data,  skid_data_n;
    logic             in_ready_n;
    logic             hlt_seen_n;
    logic [CNT_W-1:0] stall_cnt_n;
    logic             accept;
    logic             drain;

    assign accept = in_valid && in_ready;
    assign drain  = main_valid && out_ready;

    // Next-state: flush wins over storage moves; status updates on drain/stall regardless
    always_comb begin
        main_valid_n = main_valid;
        main_data_n  = main_data;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        hlt_seen_n   = hlt_seen;
        stall_cnt_n  = stall_cnt;

        if (drain && main_data[HLT_BIT]) begin
            hlt_seen_n = 1'b1;
        end
        if (main_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt_n = stall_cnt + CNT_W'(1);
        end

        if (flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (drain) begin
            if (skid_valid) begin
                // in_ready is low while skid is full, so no accept can collide here
                main_valid_n = 1'b1;
                main_data_n  = skid_data;
                skid_valid_n = 1'b0;
            end else if (accept) begin
                main_valid_n = 1'b1;
                main_data_n  = in_data;
            end else begin
                main_valid_n = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_valid_n = 1'b1;
                main_data_n  = in_data;
            end else begin
                skid_valid_n = 1'b1;
                skid_data_n  = in_data;
            end
        end

        in_ready_n = !skid_valid_n;
    end

    // State registers with synchronous reset overriding everything
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= NOP_VAL;
            skid_valid <= 1'b0;
            skid_data  <= NOP_VAL;
            in_ready   <= 1'b1;
            hlt_seen   <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            main_valid <= main_valid_n;
            main_data  <= main_data_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            in_ready   <= in_ready_n;
            hlt_seen   <= hlt_seen_n;
            stall_cnt  <= stall_cnt_n;
        end
    end

    // Output is a pure mux of registered state; bubble when main entry is empty
    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_data : NOP_VAL;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue-based scoreboard model checked every cycle,
// a table of handshake vectors with hand-derived expectations, and directed
// sequences for halt, stall saturation and mid-operation reset.
module tb_pipe_stage_skid;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;
    localparam logic [W-1:0] NOP = 16'h0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          flush = 1'b0;
    logic          hlt_seen;
    logic [CW-1:0] stall_cnt;

    pipe_stage_skid #(
        .WIDTH  (W),
        .NOP_VAL(NOP),
        .HLT_BIT(0),
        .CNT_W  (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .flush    (flush),
        .hlt_seen (hlt_seen),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scoreboard model: queue of held payloads, in order
    logic [W-1:0] q[$];
    logic         m_hlt = 1'b0;
    int           m_cnt = 0;
    logic         m_known = 1'b0;

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         fl;
        logic         eov;
        logic [W-1:0] eod;
        logic         eir;
    } vec_t;

    vec_t tv[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare DUT state to the model, drive inputs, advance the model
    task automatic step(input logic r, input logic iv, input logic [W-1:0] d,
                        input logic ordy, input logic fl);
        logic acc;
        logic drn;
        if (m_known) begin
            chk("sb_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("sb_in_ready",  32'(in_ready),  32'(q.size() < 2));
            chk("sb_out_data",  32'(out_data),  (q.size() > 0) ? 32'(q[0]) : 32'(NOP));
            chk("sb_hlt_seen",  32'(hlt_seen),  32'(m_hlt));
            chk("sb_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        end
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        if (r) begin
            q.delete();
            m_hlt   = 1'b0;
            m_cnt   = 0;
            m_known = 1'b1;
        end else begin
            acc = iv && (q.size() < 2);
            drn = (q.size() > 0) && ordy;
            if ((q.size() > 0) && !ordy && (m_cnt < 15)) m_cnt++;
            if (drn) begin
                if (q[0][0]) m_hlt = 1'b1;
                void'(q.pop_front());
            end
            if (fl) q.delete();
            else if (acc) q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // Stream / skid / flush vectors; expectations are the state after each edge
        tv[0]  = '{1'b1, 16'h1111, 1'b1, 1'b0, 1'b1, 16'h1111, 1'b1};
        tv[1]  = '{1'b1, 16'h2222, 1'b1, 1'b0, 1'b1, 16'h2222, 1'b1};
        tv[2]  = '{1'b1, 16'h3333, 1'b1, 1'b0, 1'b1, 16'h3333, 1'b1};
        tv[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
        tv[4]  = '{1'b1, 16'h1111, 1'b1, 1'b0, 1'b1, 16'h1111, 1'b1};
        tv[5]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b0};
        tv[6]  = '{1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b0};
        tv[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h2222, 1'b1};
        tv[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
        tv[9]  = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b1};
        tv[10] = '{1'b1, 16'h6666, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0};
        tv[11] = '{1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
        tv[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_out_data",  32'(out_data),  32'(NOP));
        chk("reset_hlt_seen",  32'(hlt_seen),  32'd0);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);

        for (int i = 0; i < 13; i++) begin
            step(1'b0, tv[i].iv, tv[i].d, tv[i].ordy, tv[i].fl);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tv[i].eov));
            chk($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(tv[i].eod));
            chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(tv[i].eir));
        end

        // HLT payload drained in the same cycle as a flush, then a plain flush
        do_reset();
        step(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0040, 1'b1, 1'b1);
        chk("hlt_after_drain_flush", 32'(hlt_seen),  32'd1);
        chk("flush_drops_accept",    32'(out_valid), 32'd0);
        step(1'b0, 1'b1, 16'h0080, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("hlt_after_flush", 32'(hlt_seen), 32'd1);
        do_reset();
        chk("hlt_cleared_by_rst", 32'(hlt_seen), 32'd0);

        // Stall counter saturation at 2^CW-1
        step(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
            chk($sformatf("stall_cnt_%0d", i), 32'(stall_cnt), (i < 15) ? 32'(i) : 32'd15);
        end

        // Reset with skid full and stall_cnt at 7
        do_reset();
        step(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h0200, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        chk("pre_rst_stall_cnt", 32'(stall_cnt), 32'd7);
        chk("pre_rst_in_ready",  32'(in_ready),  32'd0);
        step(1'b1, 1'b1, 16'h0300, 1'b1, 1'b1);
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_out_data",  32'(out_data),  32'(NOP));
        chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("midrst_hlt_seen",  32'(hlt_seen),  32'd0);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
